// File: rtl/aes_arb_pkg.sv
// rtl/aes_arb_pkg.sv - widths, FSM states and key-size encoding for the AES core arbiter
package aes_arb_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_ISSUE,
    ST_KEY_WAIT,
    ST_BLK_ISSUE,
    ST_BLK_WAIT
  } arb_state_t;

  typedef enum logic {
    KEY_SIZE_128 = 1'b0,
    KEY_SIZE_256 = 1'b1
  } key_size_t;

endpackage

// File: rtl/aes_core_arbiter_if.sv
// rtl/aes_core_arbiter_if.sv - control and data lines between the arbiter and the shared aes_top core
interface aes_core_arbiter_if;
  import aes_arb_pkg::*;

  logic                 aes_en_cipher;
  logic                 aes_en_decipher;
  logic                 aes_en_key;
  logic                 aes128_mode;
  logic                 aes256_mode;
  logic [AES_KEY_W-1:0] aes_key;
  logic [AES_BLK_W-1:0] aes_in_blk;
  logic [AES_BLK_W-1:0] aes_out_blk;
  logic                 aes_op_in_progress;
  logic                 aes_done;

  modport master (
    output aes_en_cipher, aes_en_decipher, aes_en_key, aes128_mode, aes256_mode,
    output aes_key, aes_in_blk,
    input  aes_out_blk, aes_op_in_progress, aes_done
  );

  modport slave (
    input  aes_en_cipher, aes_en_decipher, aes_en_key, aes128_mode, aes256_mode,
    input  aes_key, aes_in_blk,
    output aes_out_blk, aes_op_in_progress, aes_done
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting one past the last winner
module rr_arbiter #(
  parameter int  N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  // walk from the farthest candidate back to the nearest so the nearest active request wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = N; k >= 1; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - shares one aes_top between key expansion and NUM_REQ block requesters
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ          = 2,
  parameter int AES_BLK_BITS     = AES_BLK_W,
  parameter int AES_MAX_KEY_BITS = AES_KEY_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_valid,
  output logic                            key_ready,
  input  logic [AES_MAX_KEY_BITS-1:0]     key_in,
  input  logic                            key_aes256,
  input  logic                            key_invalidate,
  output logic                            key_expanded,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_decrypt,
  input  logic [NUM_REQ*AES_BLK_BITS-1:0] req_blk,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [AES_BLK_BITS-1:0]         rsp_blk,
  aes_core_arbiter_if.master              core
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state, state_next;
  logic [IW-1:0]      ptr, owner, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic               dec_q;
  logic               core_free;
  logic               grant_ok;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign core_free = !core.aes_op_in_progress;

  // next state plus the accept strobes and one-cycle core enables; key load outranks blocks
  always_comb begin
    state_next           = state;
    key_ready            = 1'b0;
    grant_ok             = 1'b0;
    req_ready            = '0;
    core.aes_en_key      = 1'b0;
    core.aes_en_cipher   = 1'b0;
    core.aes_en_decipher = 1'b0;
    case (state)
      ST_IDLE: begin
        if (core_free && key_valid) begin
          key_ready  = 1'b1;
          state_next = ST_KEY_ISSUE;
        end else if (core_free && key_expanded && (|req_valid)) begin
          grant_ok   = 1'b1;
          req_ready  = gnt;
          state_next = ST_BLK_ISSUE;
        end
      end
      ST_KEY_ISSUE: begin
        core.aes_en_key = 1'b1;
        state_next      = ST_KEY_WAIT;
      end
      ST_KEY_WAIT: begin
        if (core.aes_done) state_next = ST_IDLE;
      end
      ST_BLK_ISSUE: begin
        core.aes_en_cipher   = !dec_q;
        core.aes_en_decipher = dec_q;
        state_next           = ST_BLK_WAIT;
      end
      ST_BLK_WAIT: begin
        if (core.aes_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // key/mode latches, granted block, owner, RR pointer and the registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core.aes_key     <= '0;
      core.aes128_mode <= 1'b0;
      core.aes256_mode <= 1'b0;
      core.aes_in_blk  <= '0;
      key_expanded     <= 1'b0;
      dec_q            <= 1'b0;
      owner            <= '0;
      ptr              <= IW'(NUM_REQ - 1);
      rsp_valid        <= '0;
      rsp_blk          <= '0;
    end else begin
      rsp_valid <= '0;
      if (key_ready) begin
        core.aes_key     <= key_in;
        core.aes128_mode <= (key_size_t'(key_aes256) == KEY_SIZE_128);
        core.aes256_mode <= (key_size_t'(key_aes256) == KEY_SIZE_256);
      end
      if (grant_ok) begin
        core.aes_in_blk <= req_blk[int'(gnt_idx)*AES_BLK_BITS +: AES_BLK_BITS];
        dec_q           <= req_decrypt[gnt_idx];
        owner           <= gnt_idx;
        ptr             <= gnt_idx;
      end
      // a fresh load wins over invalidate; an in-flight block still completes afterwards
      if (key_ready || key_invalidate)              key_expanded <= 1'b0;
      else if (state == ST_KEY_WAIT && core.aes_done) key_expanded <= 1'b1;
      if (state == ST_BLK_WAIT && core.aes_done) begin
        rsp_valid[owner] <= 1'b1;
        rsp_blk          <= core.aes_out_blk;
      end
    end
  end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - vector table, corner sequences and random traffic against a core stub and scoreboard
module tb_aes_core_arbiter;
  import aes_arb_pkg::*;

  localparam int NUM_REQ = 2;
  localparam logic [255:0] K128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 key_valid = 1'b0;
  logic                 key_ready;
  logic [255:0]         key_in = '0;
  logic                 key_aes256 = 1'b0;
  logic                 key_invalidate = 1'b0;
  logic                 key_expanded;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [NUM_REQ-1:0]   req_decrypt = '0;
  logic [NUM_REQ*128-1:0] req_blk = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [127:0]         rsp_blk;

  aes_core_arbiter_if core_if();

  aes_core_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk(clk), .reset(reset),
    .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in), .key_aes256(key_aes256),
    .key_invalidate(key_invalidate), .key_expanded(key_expanded),
    .req_valid(req_valid), .req_decrypt(req_decrypt), .req_blk(req_blk), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_blk(rsp_blk),
    .core(core_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // core behaviour: real AES answers for the known vectors, an invertible stand-in otherwise
  function automatic logic [127:0] core_fn(input logic [255:0] k, input logic k256,
                                           input logic dec, input logic [127:0] b);
    logic [127:0] kk;
    logic [127:0] x;
    if (!k256 && k == K128 && !dec && b == PT)    return CT128;
    if (!k256 && k == K128 &&  dec && b == CT128) return PT;
    if ( k256 && k == K256 && !dec && b == PT)    return CT256;
    if ( k256 && k == K256 &&  dec && b == CT256) return PT;
    kk = k256 ? (k[255:128] ^ k[127:0]) : k[255:128];
    if (dec) begin
      x = b ^ kk;
      return {x[7:0], x[127:8]};
    end
    return {b[119:0], b[127:120]} ^ kk;
  endfunction

  // ---------------- aes_top stand-in ----------------
  logic         busy;
  logic         force_busy = 1'b0;
  int           cnt;
  int           core_lat = 0;
  logic         c_kop, c_k256, c_dec;
  logic [255:0] c_key;
  logic [127:0] c_blk;

  assign core_if.aes_op_in_progress = busy | force_busy;

  function automatic int pick_lat();
    return (core_lat > 0) ? core_lat : int'($urandom_range(1, 5));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0; cnt <= 0; c_kop <= 1'b0;
      core_if.aes_done <= 1'b0; core_if.aes_out_blk <= '0;
    end else begin
      core_if.aes_done <= 1'b0;
      if (core_if.aes_en_key) begin
        c_key <= core_if.aes_key; c_k256 <= core_if.aes256_mode & ~core_if.aes128_mode;
        busy <= 1'b1; cnt <= pick_lat(); c_kop <= 1'b1;
      end else if (core_if.aes_en_cipher | core_if.aes_en_decipher) begin
        c_dec <= core_if.aes_en_decipher; c_blk <= core_if.aes_in_blk;
        busy <= 1'b1; cnt <= pick_lat(); c_kop <= 1'b0;
      end else if (busy) begin
        if (cnt <= 1) begin
          busy <= 1'b0; core_if.aes_done <= 1'b1;
          if (!c_kop) core_if.aes_out_blk <= core_fn(c_key, c_k256, c_dec, c_blk);
        end else cnt <= cnt - 1;
      end
    end
  end

  // ---------------- scoreboard / protocol monitor ----------------
  typedef struct { int owner; logic [127:0] blk; } exp_t;
  exp_t               exp_q[$];
  int                 grant_log[$];
  logic [255:0]       m_key = '0;
  logic               m_k256 = 1'b0;
  int                 last_gnt, g, gi, j;
  logic               m_exp_key_en, m_exp_en, m_exp_dec, m_exp_rsp, prev_en, cur_en;
  logic [127:0]       m_exp_in;
  logic [NUM_REQ-1:0] oh;
  exp_t               e;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      last_gnt = NUM_REQ - 1;
      m_exp_key_en = 1'b0; m_exp_en = 1'b0; m_exp_rsp = 1'b0; prev_en = 1'b0;
    end else begin
      cur_en = core_if.aes_en_key | core_if.aes_en_cipher | core_if.aes_en_decipher;
      if (m_exp_key_en)
        chk("key_en_pulse", 256'({core_if.aes_en_key, core_if.aes_en_cipher, core_if.aes_en_decipher}), 256'(3'b100));
      if (m_exp_en) begin
        chk("blk_en_pulse", 256'({core_if.aes_en_key, core_if.aes_en_cipher, core_if.aes_en_decipher}),
            256'({1'b0, ~m_exp_dec, m_exp_dec}));
        chk("aes_in_blk", 256'(core_if.aes_in_blk), 256'(m_exp_in));
      end
      if (cur_en && prev_en) chk("en_back_to_back", 256'(1), 256'(0));
      if (m_exp_rsp || rsp_valid != '0) begin
        chk("rsp_timing", 256'(rsp_valid != '0), 256'(m_exp_rsp));
        if (m_exp_rsp && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          oh = '0; oh[e.owner] = 1'b1;
          chk("rsp_owner", 256'(rsp_valid), 256'(oh));
          chk("rsp_blk", 256'(rsp_blk), 256'(e.blk));
        end
      end
      if (req_ready != '0) begin
        g = -1;
        for (int k = 1; k <= NUM_REQ; k++) begin
          j = (last_gnt + k) % NUM_REQ;
          if (g < 0 && req_valid[j]) g = j;
        end
        oh = '0;
        if (g >= 0) oh[g] = 1'b1;
        chk("grant_rr", 256'(req_ready), 256'(oh));
        chk("grant_keyed", 256'(key_expanded), 256'(1));
        gi = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (req_ready[k]) gi = k;
        m_exp_dec = req_decrypt[gi];
        m_exp_in  = req_blk[gi*128 +: 128];
        exp_q.push_back('{gi, core_fn(m_key, m_k256, m_exp_dec, m_exp_in)});
        grant_log.push_back(gi);
        last_gnt = gi;
      end
      m_exp_key_en = key_ready;
      m_exp_en     = (req_ready != '0);
      m_exp_rsp    = core_if.aes_done && (exp_q.size() > 0);
      prev_en      = cur_en;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load_key(input logic [255:0] k, input logic k256);
    int n;
    @(posedge clk); #1;
    key_in = k; key_aes256 = k256; key_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!key_ready && n < 50) begin @(negedge clk); n++; end
    chk("key_accept", 256'(key_ready), 256'(1));
    m_key = k; m_k256 = k256;
    @(posedge clk); #1;
    key_valid = 1'b0;
    n = 0;
    while (!key_expanded && n < 100) begin @(negedge clk); n++; end
    chk("key_expanded_rise", 256'(key_expanded), 256'(1));
    chk("aes_key", core_if.aes_key, k);
    chk("mode_lines", 256'({core_if.aes128_mode, core_if.aes256_mode}), 256'({~k256, k256}));
  endtask

  task automatic issue(input int i, input logic dec, input logic [127:0] b);
    int n;
    @(posedge clk); #1;
    req_valid[i] = 1'b1; req_decrypt[i] = dec; req_blk[i*128 +: 128] = b;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 100) begin @(negedge clk); n++; end
    chk("req_accept", 256'(req_ready[i]), 256'(1));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output logic [127:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid[i] && n < 100) begin @(negedge clk); n++; end
    chk("rsp_seen", 256'(rsp_valid[i]), 256'(1));
    b = rsp_blk;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic watch_idle(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      seen = seen | (req_ready != '0) | core_if.aes_en_cipher | core_if.aes_en_decipher;
    end
    chk(name, 256'(seen), 256'(0));
  endtask

  typedef struct {
    logic [255:0] key; logic k256; int idx; logic dec; logic [127:0] blk; logic [127:0] exp;
  } vec_t;
  vec_t tab[4];

  task automatic run_vec(input vec_t v);
    logic [127:0] got;
    load_key(v.key, v.k256);
    issue(v.idx, v.dec, v.blk);
    wait_rsp(v.idx, got);
    chk("vec_rsp_blk", 256'(got), 256'(v.exp));
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [NUM_REQ-1:0] rdy;
    logic [127:0]       got;
    int                 start, n;
    logic [255:0]       rk;

    tab[0] = '{K128, 1'b0, 0, 1'b0, PT, CT128};
    tab[1] = '{K256, 1'b1, 1, 1'b1, CT256, PT};
    tab[2] = '{K256, 1'b1, 0, 1'b0, PT, CT256};
    tab[3] = '{{128'hdeadbeef_0badf00d_12345678_9abcdef0, 128'h0}, 1'b0, 1, 1'b1,
               128'h0f0e0d0c_0b0a0908_07060504_03020100, '0};
    tab[3].exp = core_fn(tab[3].key, 1'b0, 1'b1, tab[3].blk);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 256'({key_ready, key_expanded, req_ready, rsp_valid}), 256'(0));
    chk("rst_core_ctl", 256'({core_if.aes_en_cipher, core_if.aes_en_decipher, core_if.aes_en_key,
                              core_if.aes128_mode, core_if.aes256_mode}), 256'(0));
    chk("rst_aes_key", core_if.aes_key, 256'(0));
    chk("rst_blks", 256'({rsp_blk, core_if.aes_in_blk}), 256'(0));
    reset = 1'b1;

    // requests before any key load are never granted
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_blk[127:0] = PT;
    watch_idle("gate_no_key", 20);
    @(posedge clk); #1;
    req_valid = '0;

    for (int t = 0; t < 4; t++) run_vec(tab[t]);

    // fairness: last grant went to requester 1, so both held gives 0,1,0,1,0,1
    @(posedge clk); #1;
    req_decrypt = 2'b01; req_blk = {128'h1111, 128'h2222}; req_valid = 2'b11;
    start = grant_log.size(); n = 0;
    while (grant_log.size() < start + 6 && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = '0;
    drain();
    chk("rr_count", 256'(grant_log.size() - start), 256'(6));
    for (int k = 0; k < 6; k++)
      if (start + k < grant_log.size()) chk("rr_order", 256'(grant_log[start + k]), 256'(k % 2));

    // invalidate blocks a pending request until the next reload
    @(posedge clk); #1; key_invalidate = 1'b1;
    @(posedge clk); #1; key_invalidate = 1'b0;
    @(negedge clk);
    chk("invalidate_drop", 256'(key_expanded), 256'(0));
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_decrypt[1] = 1'b0; req_blk[255:128] = 128'h5a5a;
    watch_idle("gate_invalidated", 20);
    load_key(K256, 1'b1);
    n = 0;
    while (!req_ready[1] && n < 20) begin @(negedge clk); n++; end
    chk("grant_after_reload", 256'(req_ready[1]), 256'(1));
    @(posedge clk); #1; req_valid = '0;
    drain();

    // key and block request in the same IDLE cycle: key first
    @(posedge clk); #1;
    key_in = K128; key_aes256 = 1'b0; key_valid = 1'b1;
    req_valid[0] = 1'b1; req_decrypt[0] = 1'b0; req_blk[127:0] = PT;
    @(negedge clk);
    chk("simul_key_ready", 256'(key_ready), 256'(1));
    chk("simul_no_req_ready", 256'(req_ready), 256'(0));
    m_key = K128; m_k256 = 1'b0;
    @(posedge clk); #1; key_valid = 1'b0;
    n = 0;
    while (!req_ready[0] && n < 100) begin @(negedge clk); n++; end
    chk("simul_block_later", 256'(req_ready[0]), 256'(1));
    @(posedge clk); #1; req_valid = '0;
    wait_rsp(0, got);
    chk("simul_rsp", 256'(got), 256'(CT128));
    drain();

    // a busy core holds off every grant
    @(posedge clk); #1;
    force_busy = 1'b1; req_valid[1] = 1'b1; req_blk[255:128] = 128'h77;
    watch_idle("busy_no_grant", 8);
    @(posedge clk); #1; force_busy = 1'b0;
    n = 0;
    while (!req_ready[1] && n < 10) begin @(negedge clk); n++; end
    chk("busy_release_grant", 256'(req_ready[1]), 256'(1));
    @(posedge clk); #1; req_valid = '0;
    drain();

    // asynchronous reset while the block is in flight
    core_lat = 6;
    issue(0, 1'b0, PT);
    @(negedge clk); @(negedge clk); #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ctrl", 256'({key_ready, key_expanded, req_ready, rsp_valid, core_if.aes_en_cipher,
                              core_if.aes_en_decipher, core_if.aes_en_key, core_if.aes128_mode,
                              core_if.aes256_mode}), 256'(0));
    chk("mid_rst_key", core_if.aes_key, 256'(0));
    chk("mid_rst_blks", 256'({rsp_blk, core_if.aes_in_blk}), 256'(0));
    rdy = '0;
    repeat (8) begin @(negedge clk); rdy = rdy | rsp_valid; end
    chk("mid_rst_no_rsp", 256'(rdy), 256'(0));
    #2 reset = 1'b1;
    core_lat = 0;
    rdy = '0;
    repeat (8) begin @(negedge clk); rdy = rdy | rsp_valid; end
    chk("post_rst_no_rsp", 256'(rdy), 256'(0));
    run_vec(tab[0]);

    // random traffic against the scoreboard
    rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    load_key(rk, 1'b1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (rdy[i]) req_valid[i] = 1'b0;
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i]          = 1'b1;
          req_decrypt[i]        = 1'($urandom_range(0, 1));
          req_blk[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      force_busy = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    req_valid = '0; force_busy = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
